// File: rtl/alu_test_pkg.sv
// Shared types and constants for the byte-serial ALU test harness.
package alu_test_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD   = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB   = 4'h1;
  localparam logic [OP_W-1:0] OP_AND   = 4'h2;
  localparam logic [OP_W-1:0] OP_OR    = 4'h3;
  localparam logic [OP_W-1:0] OP_XOR   = 4'h4;
  localparam logic [OP_W-1:0] OP_NOT   = 4'h5;
  localparam logic [OP_W-1:0] OP_SHL   = 4'h6;
  localparam logic [OP_W-1:0] OP_SHR   = 4'h7;
  localparam logic [OP_W-1:0] OP_ROL   = 4'h8;
  localparam logic [OP_W-1:0] OP_ROR   = 4'h9;
  localparam logic [OP_W-1:0] OP_INC   = 4'hA;
  localparam logic [OP_W-1:0] OP_DEC   = 4'hB;
  localparam logic [OP_W-1:0] OP_MUL   = 4'hC;
  localparam logic [OP_W-1:0] OP_CMP   = 4'hD;
  localparam logic [OP_W-1:0] OP_PASSA = 4'hE;
  localparam logic [OP_W-1:0] OP_PASSB = 4'hF;

endpackage

// File: rtl/alu8_core.sv
// Combinational 8-bit ALU: 16 opcodes, results truncated to 8 bits, no flags.
module alu8_core
  import alu_test_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:   y = a + b;
      OP_SUB:   y = a - b;
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NOT:   y = ~a;
      OP_SHL:   y = {a[DATA_W-2:0], 1'b0};
      OP_SHR:   y = {1'b0, a[DATA_W-1:1]};
      OP_ROL:   y = {a[DATA_W-2:0], a[DATA_W-1]};
      OP_ROR:   y = {a[0], a[DATA_W-1:1]};
      OP_INC:   y = a + 8'd1;
      OP_DEC:   y = a - 8'd1;
      OP_MUL:   y = a * b;
      OP_CMP:   y = (a > b) ? 8'h01 : 8'h00;
      OP_PASSA: y = a;
      OP_PASSB: y = b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/alu_test.sv
// Byte-serial ALU wrapper: loads A, B, then opcode over one 8-bit bus and
// registers the result; scalar ports map straight to switches and LEDs.
module alu_test
  import alu_test_pkg::*;
(
  input  logic CLK,
  input  logic rst,
  input  logic IN0,
  input  logic IN1,
  input  logic IN2,
  input  logic IN3,
  input  logic IN4,
  input  logic IN5,
  input  logic IN6,
  input  logic IN7,
  output logic OUT0,
  output logic OUT1,
  output logic OUT2,
  output logic OUT3,
  output logic OUT4,
  output logic OUT5,
  output logic OUT6,
  output logic OUT7
);

  logic [DATA_W-1:0] w_in;
  logic [DATA_W-1:0] w_y;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_out;
  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_load_a;
  logic              w_load_b;
  logic              w_load_out;

  assign w_in = {IN7, IN6, IN5, IN4, IN3, IN2, IN1, IN0};
  assign {OUT7, OUT6, OUT5, OUT4, OUT3, OUT2, OUT1, OUT0} = r_out;

  always_ff @(posedge CLK) begin
    if (!rst) begin
      r_state <= LOAD_A;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_a    = 1'b0;
    w_load_b    = 1'b0;
    w_load_out  = 1'b0;
    case (r_state)
      LOAD_A: begin
        w_load_a    = 1'b1;
        w_state_nxt = LOAD_B;
      end
      LOAD_B: begin
        w_load_b    = 1'b1;
        w_state_nxt = LOAD_OP;
      end
      LOAD_OP: begin
        w_load_out  = 1'b1;
        w_state_nxt = LOAD_A;
      end
      default: w_state_nxt = LOAD_A;
    endcase
  end

  // Operand and result registers; OUT only moves on the opcode edge.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_out <= '0;
    end else begin
      if (w_load_a)   r_a   <= w_in;
      if (w_load_b)   r_b   <= w_in;
      if (w_load_out) r_out <= w_y;
    end
  end

  // Opcode is the live low nibble of the bus; the high nibble is ignored.
  alu8_core u_core (
    .a  (r_a),
    .b  (r_b),
    .op (w_in[OP_W-1:0]),
    .y  (w_y)
  );

endmodule

// File: tb/tb_alu_test.sv
// Self-checking bench for alu_test: directed vectors with literal expectations
// plus a per-cycle comparison against an arithmetic reference model.
module tb_alu_test;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_bus;
  wire  [7:0] out_w;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int   m_phase = 0;
  int   m_a = 0;
  int   m_b = 0;
  int   m_out = 0;
  bit   m_valid = 1'b0;

  alu_test dut (
    .CLK (clk),
    .rst (rst_n),
    .IN0 (in_bus[0]), .IN1 (in_bus[1]), .IN2 (in_bus[2]), .IN3 (in_bus[3]),
    .IN4 (in_bus[4]), .IN5 (in_bus[5]), .IN6 (in_bus[6]), .IN7 (in_bus[7]),
    .OUT0 (out_w[0]), .OUT1 (out_w[1]), .OUT2 (out_w[2]), .OUT3 (out_w[3]),
    .OUT4 (out_w[4]), .OUT5 (out_w[5]), .OUT6 (out_w[6]), .OUT7 (out_w[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_alu(input int a, input int b, input int op);
    int r;
    case (op)
      0:  r = (a + b) % 256;
      1:  r = (a - b + 256) % 256;
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = 255 - a;
      6:  r = (a * 2) % 256;
      7:  r = a / 2;
      8:  r = ((a * 2) % 256) + (a / 128);
      9:  r = (a / 2) + ((a % 2) * 128);
      10: r = (a + 1) % 256;
      11: r = (a + 255) % 256;
      12: r = (a * b) % 256;
      13: r = (a > b) ? 1 : 0;
      14: r = a;
      default: r = b;
    endcase
    return r;
  endfunction

  // Model: three-edge load cycle, reset restarts it and clears everything.
  always @(posedge clk) begin
    if (rst_n === 1'b0) begin
      m_phase = 0; m_a = 0; m_b = 0; m_out = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      case (m_phase)
        0: m_a = int'(in_bus);
        1: m_b = int'(in_bus);
        default: m_out = ref_alu(m_a, m_b, int'(in_bus[3:0]));
      endcase
      m_phase = (m_phase + 1) % 3;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (out_w !== 8'(m_out)) begin
        failures++;
        $display("FAIL model_cmp t=%0t out=%02h expected=%02h", $time, out_w, 8'(m_out));
      end
    end
  end

  task automatic drive(input logic r, input logic [7:0] v);
    @(negedge clk);
    rst_n  = r;
    in_bus = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [7:0] exp);
    checks++;
    if (out_w !== exp) begin
      failures++;
      $display("FAIL %s out=%02h expected=%02h", name, out_w, exp);
    end
  endtask

  task automatic run(input string name, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] opb, input logic [7:0] exp);
    drive(1'b1, a);
    drive(1'b1, b);
    drive(1'b1, opb);
    check_lit(name, exp);
  endtask

  initial begin
    rst_n  = 1'b0;
    in_bus = 8'h00;
    drive(1'b0, 8'hA5);
    drive(1'b0, 8'h5A);
    check_lit("reset_out", 8'h00);

    run("add", 8'h09, 8'h0A, 8'h00, 8'h13);
    drive(1'b1, 8'h77);
    check_lit("hold_a", 8'h13);
    drive(1'b1, 8'h66);
    check_lit("hold_b", 8'h13);
    drive(1'b1, 8'h01);

    run("sub_wrap", 8'h09, 8'h0A, 8'h01, 8'hFF);
    run("inc_wrap", 8'hFF, 8'h00, 8'h0A, 8'h00);
    run("dec_wrap", 8'h00, 8'h00, 8'h0B, 8'hFF);
    run("and", 8'h12, 8'h1B, 8'h02, 8'h12);
    run("or",  8'h12, 8'h1B, 8'h03, 8'h1B);
    run("xor", 8'h12, 8'h1B, 8'h04, 8'h09);
    run("not", 8'h12, 8'h1B, 8'h05, 8'hED);
    run("shl", 8'h81, 8'h1B, 8'h06, 8'h02);
    run("shr", 8'h81, 8'h1B, 8'h07, 8'h40);
    run("rol", 8'h81, 8'h1B, 8'h08, 8'h03);
    run("ror", 8'h81, 8'h1B, 8'h09, 8'hC0);
    run("mul", 8'h12, 8'h1B, 8'h0C, 8'hE6);
    run("cmp_lt", 8'h12, 8'h1B, 8'h0D, 8'h00);
    run("cmp_gt", 8'h1B, 8'h12, 8'h0D, 8'h01);
    run("cmp_eq", 8'h12, 8'h12, 8'h0D, 8'h00);
    run("passa", 8'h3C, 8'hC3, 8'h0E, 8'h3C);
    run("passb", 8'h3C, 8'hC3, 8'h0F, 8'hC3);
    run("op_hi_ignored", 8'h09, 8'h0A, 8'hF0, 8'h13);

    // Reset while in LOAD_B discards A and clears OUT.
    drive(1'b1, 8'h55);
    drive(1'b0, 8'h77);
    check_lit("midreset_clear", 8'h00);
    run("after_midreset", 8'h01, 8'h02, 8'h00, 8'h03);

    // Reset while in LOAD_OP.
    drive(1'b1, 8'h40);
    drive(1'b1, 8'h40);
    drive(1'b0, 8'h00);
    check_lit("reset_in_op", 8'h00);
    run("after_reset_op", 8'h40, 8'h03, 8'h0C, 8'hC0);

    // Back-to-back sweep over all opcodes, model-checked every cycle.
    for (int op = 0; op < 16; op++) begin
      drive(1'b1, 8'($urandom_range(0, 255)));
      drive(1'b1, 8'($urandom_range(0, 255)));
      drive(1'b1, {4'($urandom_range(0, 15)), 4'(op)});
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
